// File: rtl/load_store_unit_if.sv
// Request/response handshake plus Data_Memory port of the load/store unit.
// master: the requester that also owns the memory; slave: the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  modport master (
    output req, we, funct3, addr, wdata, mem_rd,
    input  ready, done, err, rdata, mem_addr, mem_we, mem_wd
  );

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rd,
    output ready, done, err, rdata, mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding RISC-V load/store unit in front of a word-wide Data_Memory.
// Sub-word stores are done as read-modify-write; loads are sign/zero-extended.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StRmwRd = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StResp  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       merge_q, merge_d;

  logic              req_err;
  logic              size_ok;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_ext;
  logic [31:0]       store_word;

  // Request legality is decided on the live inputs, at acceptance time.
  always_comb begin
    size_ok = 1'b0;
    unique case (bus.funct3)
      3'b000, 3'b100: size_ok = 1'b1;
      3'b001, 3'b101: size_ok = ~bus.addr[0];
      3'b010:         size_ok = (bus.addr[1:0] == 2'b00);
      default:        size_ok = 1'b0;
    endcase
    req_err = ~size_ok | (bus.we & bus.funct3[2]);
  end

  always_comb begin
    load_byte = 8'h00;
    unique case (addr_q[1:0])
      2'b00: load_byte = bus.mem_rd[7:0];
      2'b01: load_byte = bus.mem_rd[15:8];
      2'b10: load_byte = bus.mem_rd[23:16];
      2'b11: load_byte = bus.mem_rd[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

    load_ext = bus.mem_rd;
    unique case (funct3_q)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_ext = {24'h000000, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b101:  load_ext = {16'h0000, load_half};
      default: load_ext = bus.mem_rd;
    endcase
  end

  // Merge the store data into the word captured during the read phase.
  always_comb begin
    store_word = merge_q;
    unique case (funct3_q[1:0])
      2'b00: begin
        unique case (addr_q[1:0])
          2'b00: store_word[7:0]   = wdata_q[7:0];
          2'b01: store_word[15:8]  = wdata_q[7:0];
          2'b10: store_word[23:16] = wdata_q[7:0];
          2'b11: store_word[31:24] = wdata_q[7:0];
          default: store_word = merge_q;
        endcase
      end
      2'b01: begin
        if (addr_q[1]) begin
          store_word[31:16] = wdata_q[15:0];
        end else begin
          store_word[15:0] = wdata_q[15:0];
        end
      end
      2'b10:   store_word = wdata_q;
      default: store_word = merge_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    merge_d  = merge_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          we_d     = bus.we;
          funct3_d = bus.funct3;
          addr_d   = bus.addr;
          wdata_d  = bus.wdata;
          err_d    = req_err;
          if (req_err) begin
            state_d = StResp;
          end else if (!bus.we) begin
            state_d = StLoad;
          end else if (bus.funct3 == 3'b010) begin
            state_d = StWrite;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        rdata_d = load_ext;
        state_d = StResp;
      end
      StRmwRd: begin
        merge_d = bus.mem_rd;
        state_d = StWrite;
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      merge_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      merge_q  <= merge_d;
    end
  end

  // mem_we is decoded from state alone, so it cannot pulse outside WRITE.
  always_comb begin
    bus.ready  = (state_q == StIdle);
    bus.done   = (state_q == StResp);
    bus.err    = (state_q == StResp) & err_q;
    bus.rdata  = rdata_q;
    bus.mem_we = (state_q == StWrite) & we_q;
    bus.mem_wd = (state_q == StWrite) ? store_word : 32'h0;
    if ((state_q == StLoad) || (state_q == StRmwRd) || (state_q == StWrite)) begin
      bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    end else begin
      bus.mem_addr = '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural memory model predicts every
// response, and a negedge monitor pops and compares whenever done is raised.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_clr = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   we_cnt = 0;
  int   we_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data_Memory: combinational read, write on rising edge.
  logic [31:0] mem [16];
  assign bus.mem_rd = mem[bus.mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[5:2]] <= bus.mem_wd;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    int          idx;
    logic [31:0] word;
    int          we_n;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [16];
  logic [31:0] model_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural view: byte-addressed memory, accesses by size in bytes.
  function automatic exp_t ref_access(input logic we, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          size;
    int          off;
    logic [31:0] old;
    logic [31:0] sh;
    logic [31:0] mask;
    off   = int'(a[1:0]);
    e.idx = int'(a[5:2]);
    old   = model_mem[e.idx];
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.err = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3[2]) || ((a % size) != 0);
    e.word  = old;
    e.we_n  = 0;
    e.rdata = model_rdata;
    e.acc   = 0;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      sh = old >> (8 * off);
      if (size == 1) e.rdata = f3[2] ? {24'h0, sh[7:0]} : 32'($signed(sh[7:0]));
      else if (size == 2) e.rdata = f3[2] ? {16'h0, sh[15:0]} : 32'($signed(sh[15:0]));
      else e.rdata = old;
      model_rdata = e.rdata;
      e.lat = 2;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
      mask = mask << (8 * off);
      e.word = (old & ~mask) | ((wd << (8 * off)) & mask);
      model_mem[e.idx] = e.word;
      e.we_n = 1;
      e.lat = (size == 4) ? 2 : 3;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_we) begin
      we_cnt++;
      we_total++;
    end
    if (rst_n && bus.ready) begin
      check("idle_mem_addr", bus.mem_addr, 32'h0);
      check("idle_mem_wd", bus.mem_wd, 32'h0);
      check("idle_mem_we", {31'h0, bus.mem_we}, 32'h0);
    end
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        e = sb.pop_front();
        check("err", {31'h0, bus.err}, {31'h0, e.err});
        check("rdata", bus.rdata, e.rdata);
        check("latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
        check("mem_we_pulses", 32'(we_cnt), 32'(e.we_n));
        check("mem_word", mem[e.idx], e.word);
        check("ready_in_resp", {31'h0, bus.ready}, 32'h0);
        check("resp_mem_addr", bus.mem_addr, 32'h0);
      end
      we_cnt = 0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    exp_t e;
    int   n;
    wait_ready();
    e = ref_access(we, f3, a, wd);
    bus.req    = 1'b1;
    bus.we     = we;
    bus.funct3 = f3;
    bus.addr   = a;
    bus.wdata  = wd;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    // Scramble inputs while busy: latched fields and the ignored req must not matter.
    n = 0;
    while (!bus.done && n < 10) begin
      bus.req    = 1'($urandom);
      bus.we     = 1'($urandom);
      bus.funct3 = 3'($urandom);
      bus.addr   = $urandom;
      bus.wdata  = $urandom;
      @(posedge clk);
      #1;
      n++;
    end
    bus.req = 1'b0;
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected 1 within 10 cycles");
    end
  endtask

  initial begin
    logic [2:0] f3;
    logic       we;
    int         we0;
    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.funct3 = 3'b000;
    bus.addr = 32'h0;
    bus.wdata = 32'h0;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    model_rdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, bus.ready}, 32'h1);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_err", {31'h0, bus.err}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    mem_clr = 1'b0;

    issue(1'b1, 3'b010, 32'h8, 32'h0000_000B);
    issue(1'b1, 3'b010, 32'h8, 32'h1122_3344);
    issue(1'b1, 3'b000, 32'h9, 32'h0000_00AA);
    wait_ready();
    check("sb_merge_word", mem[2], 32'h1122_AA44);
    issue(1'b1, 3'b010, 32'h8, 32'h8022_AA44);
    issue(1'b0, 3'b000, 32'hB, 32'h0);
    wait_ready();
    check("lb_value", bus.rdata, 32'hFFFF_FF80);
    issue(1'b0, 3'b100, 32'hB, 32'h0);
    wait_ready();
    check("lbu_value", bus.rdata, 32'h0000_0080);
    issue(1'b0, 3'b001, 32'hA, 32'h0);
    wait_ready();
    check("lh_value", bus.rdata, 32'hFFFF_8022);
    issue(1'b0, 3'b101, 32'hA, 32'h0);
    wait_ready();
    check("lhu_value", bus.rdata, 32'h0000_8022);
    issue(1'b0, 3'b010, 32'h6, 32'h0);
    issue(1'b0, 3'b011, 32'h8, 32'h0);
    issue(1'b1, 3'b100, 32'h8, 32'hFFFF_FFFF);
    issue(1'b1, 3'b001, 32'h7, 32'hFFFF_FFFF);

    // SH abandoned by reset while in the read phase of read-modify-write.
    wait_ready();
    bus.req = 1'b1;
    bus.we = 1'b1;
    bus.funct3 = 3'b001;
    bus.addr = 32'hA;
    bus.wdata = 32'h0000_5555;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    rst_n = 1'b0;
    we0 = we_total;
    repeat (2) @(posedge clk);
    #1;
    check("rst_abort_no_we", 32'(we_total), 32'(we0));
    check("rst_abort_mem", mem[2], model_mem[2]);
    check("rst_abort_ready", {31'h0, bus.ready}, 32'h1);
    check("rst_abort_done", {31'h0, bus.done}, 32'h0);
    check("rst_abort_rdata", bus.rdata, 32'h0);
    model_rdata = 32'h0;
    rst_n = 1'b1;

    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom);
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
      issue(we, f3, 32'($urandom_range(0, 63)), $urandom);
    end

    wait_ready();
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
